antifurto_timer: RTL and testbench

Programmable countdown timer that serves the anti-theft controller's timer interface. It accepts a one-cycle `start_timer` request with a 2-bit `interval` selector and counts down the selected delay in seconds using the external `one_hz_enable` tick. It signals completion with a one-cycle `expired` pulse. Four delay values are held in on-chip registers, loaded with defaults at reset and rewritable through the `reprogram` port.

---
 rtl/antifurto_timer.sv | 118 +++++++++++
 tb/tb_antifurto_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/antifurto_timer.sv
// Countdown timer for the anti-theft controller: four programmable second
// delays, one-cycle start/retrigger, registered busy/expired/remaining outputs.
module antifurto_timer #(
    parameter logic [3:0] T_ARM_DEFAULT    = 4'd6,
    parameter logic [3:0] T_DRIVER_DEFAULT = 4'd8,
    parameter logic [3:0] T_PASS_DEFAULT   = 4'd15,
    parameter logic [3:0] T_ALARM_DEFAULT  = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_hz_enable,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] count_r;
    logic [3:0] delay_r [4];
    logic       expired_r;
    logic       busy_r;

    assign expired   = expired_r;
    assign busy      = busy_r;
    assign remaining = count_r;

    // Delay register file: defaults on reset, zero-valued writes are rejected
    always_ff @(posedge clock) begin
        if (reset) begin
            delay_r[0] <= T_ARM_DEFAULT;
            delay_r[1] <= T_DRIVER_DEFAULT;
            delay_r[2] <= T_PASS_DEFAULT;
            delay_r[3] <= T_ALARM_DEFAULT;
        end else if (reprogram && (time_value != 4'd0)) begin
            delay_r[time_param_sel] <= time_value;
        end else begin
            delay_r <= delay_r;
        end
    end

    // Countdown FSM; start has priority over the tick, so a coincident tick is lost
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= 4'd0;
            expired_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    expired_r <= 1'b0;
                    if (start_timer) begin
                        state_r <= COUNT;
                        count_r <= delay_r[interval];
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        count_r <= 4'd0;
                        busy_r  <= 1'b0;
                    end
                end
                COUNT: begin
                    if (start_timer) begin
                        state_r   <= COUNT;
                        count_r   <= delay_r[interval];
                        busy_r    <= 1'b1;
                        expired_r <= 1'b0;
                    end else if (one_hz_enable && (count_r > 4'd1)) begin
                        state_r   <= COUNT;
                        count_r   <= count_r - 4'd1;
                        busy_r    <= 1'b1;
                        expired_r <= 1'b0;
                    end else if (one_hz_enable) begin
                        state_r   <= EXPIRE;
                        count_r   <= 4'd0;
                        busy_r    <= 1'b0;
                        expired_r <= 1'b1;
                    end else begin
                        state_r   <= COUNT;
                        count_r   <= count_r;
                        busy_r    <= 1'b1;
                        expired_r <= 1'b0;
                    end
                end
                EXPIRE: begin
                    expired_r <= 1'b0;
                    if (start_timer) begin
                        state_r <= COUNT;
                        count_r <= delay_r[interval];
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        count_r <= 4'd0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    count_r   <= 4'd0;
                    expired_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_antifurto_timer.sv
// Directed self-checking bench for antifurto_timer: countdown, reprogramming,
// retrigger, chaining, reset abort and idle ticks.
module tb_antifurto_timer;

    logic       clock = 1'b0;
    logic       reset;
    logic       one_hz_enable;
    logic       start_timer;
    logic [1:0] interval;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;

    int errors = 0;
    int checks = 0;

    antifurto_timer dut (
        .clock          (clock),
        .reset          (reset),
        .one_hz_enable  (one_hz_enable),
        .start_timer    (start_timer),
        .interval       (interval),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .expired        (expired),
        .busy           (busy),
        .remaining      (remaining)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic st, input logic [1:0] iv, input logic tk,
                        input logic rp, input logic [1:0] sel, input logic [3:0] val);
        start_timer    = st;
        interval       = iv;
        one_hz_enable  = tk;
        reprogram      = rp;
        time_param_sel = sel;
        time_value     = val;
        @(posedge clock);
        #1;
        start_timer   = 1'b0;
        one_hz_enable = 1'b0;
        reprogram     = 1'b0;
    endtask

    task automatic outs(input string tag, input logic e, input logic b, input logic [3:0] r);
        check({tag, ".expired"}, {3'd0, expired}, {3'd0, e});
        check({tag, ".busy"}, {3'd0, busy}, {3'd0, b});
        check({tag, ".remaining"}, remaining, r);
    endtask

    initial begin
        reset = 1'b1;
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;
        outs("reset", 1'b0, 1'b0, 4'd0);

        // Driver delay: 8 ticks
        step(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("drv_load", 1'b0, 1'b1, 4'd8);
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("drv_hold", 1'b0, 1'b1, 4'd8);
        for (int k = 1; k < 8; k++) begin
            step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
            outs("drv_tick", 1'b0, 1'b1, 4'(8 - k));
        end
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("drv_expire", 1'b1, 1'b0, 4'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("drv_after", 1'b0, 1'b0, 4'd0);

        // Reprogram passenger delay to 3
        step(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd3);
        outs("reprog_idle", 1'b0, 1'b0, 4'd0);
        step(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("pass3_load", 1'b0, 1'b1, 4'd3);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("pass3_t2", 1'b0, 1'b1, 4'd1);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("pass3_expire", 1'b1, 1'b0, 4'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);

        // Zero write is ignored
        step(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd0);
        step(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("zero_write", 1'b0, 1'b1, 4'd3);
        // Write during a count leaves the count untouched
        step(1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd9);
        outs("write_mid", 1'b0, 1'b1, 4'd2);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("write_mid_exp", 1'b1, 1'b0, 4'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("write_next", 1'b0, 1'b1, 4'd9);
        step(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0);

        // Retrigger: driver, 4 ticks, then alarm
        outs("retrig_load", 1'b0, 1'b1, 4'd8);
        for (int k = 0; k < 4; k++) step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("retrig_4", 1'b0, 1'b1, 4'd4);
        step(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("retrig_alarm", 1'b0, 1'b1, 4'd10);
        for (int k = 0; k < 9; k++) step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("retrig_9", 1'b0, 1'b1, 4'd1);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("retrig_expire", 1'b1, 1'b0, 4'd0);

        // Chain: start during the expired cycle
        step(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("chain", 1'b0, 1'b1, 4'd10);
        // Start with coincident tick: tick discarded
        step(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("start_tick", 1'b0, 1'b1, 4'd6);
        step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("arm_t1", 1'b0, 1'b1, 4'd5);

        // Reset mid-count, with a reprogram attempt that must be ignored
        reset = 1'b1;
        step(1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd2);
        reset = 1'b0;
        outs("rst_mid", 1'b0, 1'b0, 4'd0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("rst_after", 1'b0, 1'b0, 4'd0);
        step(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0);
        outs("rst_default", 1'b0, 1'b1, 4'd15);

        // Ticks in idle
        reset = 1'b1;
        step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
            outs("idle_tick", 1'b0, 1'b0, 4'd0);
        end
        step(1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0);
        outs("idle_start_tick", 1'b0, 1'b1, 4'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
